// File: rtl/add_sub_accumulator.sv
// add_sub_accumulator: frames of NUM_OPS add/subtract steps into an NUM_BIT
// accumulator with carry, sticky signed-overflow, zero and negative flags.
// The result is held in DONE until the consumer handshakes it away.
module add_sub_accumulator #(
  parameter int unsigned NUM_BIT = 8,
  parameter int unsigned NUM_OPS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               m,
  input  logic [NUM_BIT-1:0] operand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_BIT-1:0] acc_out,
  output logic               c_flag,
  output logic               v_flag,
  output logic               z_flag,
  output logic               n_flag
);

  localparam int unsigned CW = $clog2(NUM_OPS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_OPS - 1);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_BIT-1:0] acc_q, acc_d;
  logic               c_q, c_d;
  logic               v_q, v_d;

  logic [NUM_BIT-1:0] addend;
  logic [NUM_BIT:0]   sum;
  logic               step_ovf;
  logic               accept;
  logic               release_res;

  // Subtract is acc + ~operand + 1; overflow when both addends share a sign
  // that the result does not.
  always_comb begin
    addend   = m ? ~operand : operand;
    sum      = {1'b0, acc_q} + {1'b0, addend} + {{NUM_BIT{1'b0}}, m};
    step_ovf = (acc_q[NUM_BIT-1] == addend[NUM_BIT-1]) &&
               (sum[NUM_BIT-1] != acc_q[NUM_BIT-1]);
  end

  assign accept      = in_valid && (state_q == ACC);
  assign release_res = out_ready && (state_q == DONE);

  // Next-state selection: clr overrides both accept and result handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    c_d     = c_q;
    v_d     = v_q;
    if (clr || release_res) begin
      state_d = ACC;
      cnt_d   = '0;
      acc_d   = '0;
      c_d     = 1'b0;
      v_d     = 1'b0;
    end else if (accept) begin
      acc_d = sum[NUM_BIT-1:0];
      c_d   = sum[NUM_BIT];
      v_d   = v_q | step_ovf;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = DONE;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign c_flag    = c_q;
  assign v_flag    = v_q;
  assign z_flag    = (acc_q == '0);
  assign n_flag    = acc_q[NUM_BIT-1];

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Directed bench for add_sub_accumulator (NUM_BIT=8, NUM_OPS=4).
module tb_add_sub_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic       m;
  logic [7:0] operand;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] acc_out;
  logic       c_flag;
  logic       v_flag;
  logic       z_flag;
  logic       n_flag;

  int unsigned n_cmp;
  int unsigned n_err;

  add_sub_accumulator #(
    .NUM_BIT(8),
    .NUM_OPS(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .m        (m),
    .operand  (operand),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .c_flag   (c_flag),
    .v_flag   (v_flag),
    .z_flag   (z_flag),
    .n_flag   (n_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand for a single edge.
  task automatic send(input logic sub, input logic [7:0] op);
    in_valid = 1'b1;
    m        = sub;
    operand  = op;
    step();
    in_valid = 1'b0;
    m        = 1'b0;
    operand  = '0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b1;
    m         = 1'b0;
    operand   = 8'd7;
    out_ready = 1'b0;

    // Reset state, with an operand offered that must be ignored.
    #2;
    check("rst_acc", acc_out, 0);
    check("rst_z", z_flag, 1);
    check("rst_n", n_flag, 0);
    check("rst_c", c_flag, 0);
    check("rst_v", v_flag, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    step();
    step();
    check("rst_no_accept", acc_out, 0);
    in_valid = 1'b0;
    operand  = '0;
    rst_n    = 1'b1;
    step();

    // Plain adds: 5+12+3+10 = 30.
    send(1'b0, 8'd5);
    send(1'b0, 8'd12);
    send(1'b0, 8'd3);
    check("add3_acc", acc_out, 20);
    check("add3_out_valid", out_valid, 0);
    check("add3_in_ready", in_ready, 1);
    send(1'b0, 8'd10);
    check("add_out_valid", out_valid, 1);
    check("add_acc", acc_out, 30);
    check("add_c", c_flag, 0);
    check("add_v", v_flag, 0);
    check("add_z", z_flag, 0);
    check("add_n", n_flag, 0);
    check("add_in_ready", in_ready, 0);
    release_result();
    check("rel1_acc", acc_out, 0);
    check("rel1_in_ready", in_ready, 1);
    check("rel1_out_valid", out_valid, 0);

    // +5 -12 +0 +0 = 0xF9; 5+0xF3+1 = 249 gives no carry (borrow).
    send(1'b0, 8'd5);
    send(1'b1, 8'd12);
    check("sub_acc", acc_out, 249);
    check("sub_c", c_flag, 0);
    check("sub_n", n_flag, 1);
    check("sub_v", v_flag, 0);
    send(1'b0, 8'd0);
    // out_ready alongside the final accept has no effect in ACC.
    out_ready = 1'b1;
    send(1'b0, 8'd0);
    out_ready = 1'b0;
    check("sub_out_valid", out_valid, 1);
    check("sub_fin_acc", acc_out, 249);
    check("sub_fin_n", n_flag, 1);
    check("sub_fin_v", v_flag, 0);
    release_result();

    // 100+100 overflows signed range; v sticks through the frame.
    send(1'b0, 8'd100);
    send(1'b0, 8'd100);
    check("ovf_acc", acc_out, 200);
    check("ovf_v", v_flag, 1);
    check("ovf_c", c_flag, 0);
    send(1'b0, 8'd0);
    send(1'b0, 8'd0);
    check("ovf_out_valid", out_valid, 1);
    check("ovf_v_sticky", v_flag, 1);

    // Stall in DONE with operands offered: nothing consumed.
    in_valid = 1'b1;
    operand  = 8'd55;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_acc", acc_out, 200);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    operand   = '0;
    check("stall_rel_acc", acc_out, 0);
    check("stall_rel_in_ready", in_ready, 1);
    check("stall_rel_v", v_flag, 0);

    // clr with a simultaneous accept drops the operand and restarts the frame.
    send(1'b0, 8'd7);
    send(1'b0, 8'd9);
    check("pre_clr_acc", acc_out, 16);
    clr = 1'b1;
    send(1'b0, 8'd50);
    clr = 1'b0;
    check("clr_acc", acc_out, 0);
    check("clr_in_ready", in_ready, 1);
    check("clr_out_valid", out_valid, 0);
    send(1'b0, 8'd10);
    send(1'b1, 8'd3);
    // 10 + 0xFC + 1 = 263: carry out set (no borrow).
    check("clr_f_acc", acc_out, 7);
    check("clr_f_c", c_flag, 1);
    step();
    step();
    check("idle_acc", acc_out, 7);
    send(1'b0, 8'd1);
    check("clr_f3_out_valid", out_valid, 0);
    send(1'b0, 8'd2);
    check("clr_f_out_valid", out_valid, 1);
    check("clr_f_fin_acc", acc_out, 10);
    check("clr_f_fin_c", c_flag, 0);

    // Async reset while in DONE, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_acc", acc_out, 0);
    check("arst_z", z_flag, 1);
    check("arst_in_ready", in_ready, 1);
    #2;
    rst_n = 1'b1;
    step();
    send(1'b0, 8'd1);
    send(1'b0, 8'd1);
    send(1'b0, 8'd1);
    send(1'b0, 8'd1);
    check("resume_out_valid", out_valid, 1);
    check("resume_acc", acc_out, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
